// File: rtl/programmable_countdown_pkg.sv
// Shared synth timing definitions.
//   MODE_ONESHOT : counter stops at 0 after its terminal count.
//   MODE_RELOAD  : counter reloads from its reload register after reaching 0.
package programmable_countdown_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/programmable_countdown_tick_prescaler.sv
// tick_prescaler: clock-enable divider used by the synth timing blocks.
// A tick is produced once every prescale+1 enabled cycles.
//   clk      : system clock
//   reset    : asynchronous active-high reset, clears the divider
//   clear    : synchronous restart of the divider (takes priority over enable)
//   enable   : advances the divider when high, holds it when low
//   prescale : divide ratio minus one
//   tick     : combinational, high on the enabled cycle that ends a division
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  at_limit;

  // >= rather than == so that lowering prescale below the current pc
  // produces a tick on the next enabled cycle instead of a full wrap.
  assign at_limit = (pc_q >= prescale);
  assign tick     = enable && at_limit;

  always_comb begin
    pc_d = pc_q;
    if (clear) begin
      pc_d = '0;
    end else if (enable) begin
      pc_d = at_limit ? '0 : pc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/programmable_countdown.sv
// programmable_countdown: parametrised down-counter for synth timing
// (tone period, envelope step, note-length timers).
// With auto_reload=1, prescale=0, enable=1 and no load it counts
// RESET_VALUE..0 and wraps, matching the legacy free-running countdown.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   enable      : advances the prescaler; all state holds when low
//   load        : synchronous load of count and reload register (highest priority)
//   load_value  : value written on load
//   auto_reload : 1 = reload on expiry, 0 = one-shot
//   prescale    : tick every prescale+1 enabled cycles
//   count       : registered current count
//   tc          : registered one-cycle pulse as count first reads 0
//   running     : high while counting is active
module programmable_countdown
  import programmable_countdown_pkg::*;
#(
  parameter int                 WIDTH       = 5,
  parameter int                 PRESCALE_W  = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  running
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             running_q, running_d;
  logic             tc_q, tc_d;
  logic             tick;

  // The prescaler only advances while counting is active; load restarts it.
  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (load),
    .enable   (enable && running_q),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    running_d = running_q;
    tc_d      = 1'b0;
    if (load) begin
      // Load wins over a coincident tick, so that tick never yields a tc.
      count_d   = load_value;
      reload_d  = load_value;
      running_d = 1'b1;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        tc_d    = 1'b1;
        if (auto_reload == MODE_ONESHOT) running_d = 1'b0;
      end else if (auto_reload == MODE_RELOAD) begin
        // Reaching here from a zero load keeps count at 0 with no tc.
        count_d = reload_q;
      end else begin
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= RESET_VALUE;
      reload_q  <= RESET_VALUE;
      running_q <= 1'b1;
      tc_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      tc_q      <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = running_q;

endmodule

// File: tb/tb_programmable_countdown.sv
module tb_programmable_countdown;

  localparam int         W  = 5;
  localparam int         PW = 4;
  localparam logic [W-1:0] RV = {W{1'b1}};

  logic          clk;
  logic          reset;
  logic          enable;
  logic          load;
  logic [W-1:0]  load_value;
  logic          auto_reload;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tc;
  logic          running;

  int vec;
  int err;

  // reference model state
  int m_count, m_reload, m_pc;
  bit m_running, m_tc;

  programmable_countdown #(
    .WIDTH       (W),
    .PRESCALE_W  (PW),
    .RESET_VALUE (RV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .tc          (tc),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one clock edge, written from the counter's rules.
  task automatic model_edge();
    bit t;
    if (load) begin
      m_count = int'(load_value); m_reload = int'(load_value);
      m_pc = 0; m_running = 1; m_tc = 0;
    end else if (!enable || !m_running) begin
      m_tc = 0;
    end else begin
      t = (m_pc >= int'(prescale));
      m_pc = t ? 0 : m_pc + 1;
      m_tc = 0;
      if (t) begin
        if (m_count > 1) m_count = m_count - 1;
        else if (m_count == 1) begin
          m_count = 0; m_tc = 1;
          if (!auto_reload) m_running = 0;
        end else if (auto_reload) m_count = m_reload;
        else m_running = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_count = int'(RV); m_reload = int'(RV); m_pc = 0; m_running = 1; m_tc = 0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; load = 0; load_value = '0; auto_reload = 1; prescale = '0;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    vec++;
    if ({count, tc, running} !== {RV, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL reset: count=%0d tc=%0b running=%0b, want count=%0d tc=0 running=1", count, tc, running, RV);
    end
    reset = 0;
  endtask

  task automatic test_legacy();
    int first_tc;
    first_tc = -1;
    for (int i = 1; i <= 70; i++) begin
      step();
      vec++;
      if ({count, tc, running} !== {W'(m_count), m_tc, m_running}) begin
        err++;
        $display("FAIL legacy cyc%0d: count=%0d tc=%0b run=%0b, want %0d %0b %0b", i, count, tc, running, m_count, m_tc, m_running);
      end
      if (tc && first_tc < 0) first_tc = i;
    end
    vec++;
    if (first_tc != 31) begin
      err++;
      $display("FAIL legacy_first_tc: got cycle %0d, want 31", first_tc);
    end
  endtask

  task automatic test_oneshot();
    int tcs;
    tcs = 0;
    auto_reload = 0; prescale = 4'd2; load = 1; load_value = 5'd3;
    step();
    load = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (tc) tcs++;
      vec++;
      if ({count, tc, running} !== {W'(m_count), m_tc, m_running}) begin
        err++;
        $display("FAIL oneshot cyc%0d: count=%0d tc=%0b run=%0b, want %0d %0b %0b", i, count, tc, running, m_count, m_tc, m_running);
      end
    end
    vec++;
    if (tcs != 1 || count !== 5'd0 || running !== 1'b0) begin
      err++;
      $display("FAIL oneshot_end: tcs=%0d count=%0d running=%0b, want 1 0 0", tcs, count, running);
    end
  endtask

  task automatic test_reload_mid();
    int n;
    auto_reload = 1; prescale = '0; load = 1; load_value = 5'd10;
    step();
    load = 0;
    n = 0;
    while (m_count != 6 && n < 40) begin step(); n++; end
    load = 1; load_value = 5'd4;
    step();
    load = 0;
    vec++;
    if (count !== 5'd4) begin
      err++;
      $display("FAIL reload_mid_load: count=%0d, want 4", count);
    end
    n = 0;
    do begin step(); n++; end while (!tc && n < 40);
    vec++;
    if (n != 4) begin
      err++;
      $display("FAIL reload_mid_first_tc: %0d ticks, want 4", n);
    end
    n = 0;
    do begin step(); n++; end while (!tc && n < 40);
    vec++;
    if (n != 5) begin
      err++;
      $display("FAIL reload_mid_period: %0d ticks, want 5", n);
    end
  endtask

  task automatic test_load_tick();
    int n;
    auto_reload = 1; prescale = '0; load = 1; load_value = 5'd7;
    step();
    load = 0; n = 0;
    while (m_count != 1 && n < 40) begin step(); n++; end
    load = 1; load_value = 5'd9;
    step();
    load = 0;
    vec++;
    if ({count, tc} !== {5'd9, 1'b0}) begin
      err++;
      $display("FAIL load_tick: count=%0d tc=%0b, want 9 0", count, tc);
    end
  endtask

  task automatic test_enable_gating();
    logic [W-1:0] frozen;
    auto_reload = 1; prescale = 4'd1; load = 1; load_value = 5'd20;
    step();
    load = 0;
    repeat (5) step();
    enable = 0;
    frozen = count;
    for (int i = 0; i < 7; i++) begin
      step();
      vec++;
      if ({count, tc} !== {frozen, 1'b0}) begin
        err++;
        $display("FAIL gating_hold%0d: count=%0d tc=%0b, want %0d 0", i, count, tc, frozen);
      end
    end
    enable = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      vec++;
      if ({count, tc, running} !== {W'(m_count), m_tc, m_running}) begin
        err++;
        $display("FAIL gating_resume%0d: count=%0d tc=%0b run=%0b, want %0d %0b %0b", i, count, tc, running, m_count, m_tc, m_running);
      end
    end
  endtask

  task automatic test_period();
    int p, r, n;
    for (int k = 0; k < 3; k++) begin
      p = $urandom_range(0, 3); r = $urandom_range(2, 9);
      auto_reload = 1; prescale = PW'(p); load = 1; load_value = W'(r);
      step();
      load = 0; n = 0;
      do begin step(); n++; end while (!tc && n < 200);
      vec++;
      if (n != r * (p + 1)) begin
        err++;
        $display("FAIL period_first r=%0d p=%0d: %0d cycles, want %0d", r, p, n, r * (p + 1));
      end
      n = 0;
      do begin step(); n++; end while (!tc && n < 200);
      vec++;
      if (n != (r + 1) * (p + 1)) begin
        err++;
        $display("FAIL period r=%0d p=%0d: %0d cycles, want %0d", r, p, n, (r + 1) * (p + 1));
      end
    end
  endtask

  task automatic test_load_zero();
    int tcs;
    tcs = 0;
    auto_reload = 1; prescale = '0; load = 1; load_value = '0;
    step();
    load = 0;
    repeat (10) begin step(); if (tc) tcs++; end
    vec++;
    if (tcs != 0 || count !== '0 || running !== 1'b1) begin
      err++;
      $display("FAIL zero_auto: tcs=%0d count=%0d running=%0b, want 0 0 1", tcs, count, running);
    end
    auto_reload = 0; load = 1;
    step();
    load = 0;
    step();
    vec++;
    if ({count, tc, running} !== {5'd0, 1'b0, 1'b0}) begin
      err++;
      $display("FAIL zero_oneshot: count=%0d tc=%0b running=%0b, want 0 0 0", count, tc, running);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      enable      = ($urandom_range(0, 7) != 0);
      load        = ($urandom_range(0, 15) == 0);
      load_value  = W'($urandom_range(0, 12));
      if ($urandom_range(0, 31) == 0) auto_reload = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 3));
      step();
      vec++;
      if ({count, tc, running} !== {W'(m_count), m_tc, m_running}) begin
        err++;
        $display("FAIL random%0d: count=%0d tc=%0b run=%0b, want %0d %0b %0b", i, count, tc, running, m_count, m_tc, m_running);
      end
    end
    enable = 1; load = 0;
  endtask

  task automatic test_async_reset();
    int n;
    auto_reload = 1; prescale = '0; load = 1; load_value = 5'd12;
    step();
    load = 0; n = 0;
    while (m_count != 5 && n < 40) begin step(); n++; end
    #3 reset = 1;
    #1;
    vec++;
    if ({count, tc, running} !== {RV, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL async_reset: count=%0d tc=%0b running=%0b, want %0d 0 1", count, tc, running, RV);
    end
    #1 reset = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      vec++;
      if ({count, tc, running} !== {W'(m_count), m_tc, m_running}) begin
        err++;
        $display("FAIL after_reset%0d: count=%0d tc=%0b run=%0b, want %0d %0b %0b", i, count, tc, running, m_count, m_tc, m_running);
      end
    end
  endtask

  initial begin
    vec = 0; err = 0;
    test_reset();
    test_legacy();
    test_oneshot();
    test_reload_mid();
    test_load_tick();
    test_enable_gating();
    test_period();
    test_load_zero();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
